// File: rtl/alu_wide_sequencer.sv
// Sequences one WORDS*WIDTH-bit command through a WIDTH-bit ALU, one limb per cycle, LSB limb first.
// Optional feature: define ALU_WIDE_SEQ_PARITY_EN to drive rsp_parity from the registered result.
module alu_wide_sequencer #(
   parameter int WIDTH = 8,
   parameter int WORDS = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [3:0]               cmd_op,
   input  logic [WORDS*WIDTH-1:0]   cmd_a,
   input  logic [WORDS*WIDTH-1:0]   cmd_b,
   input  logic                     cmd_cin,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [WORDS*WIDTH-1:0]   rsp_result,
   output logic                     rsp_carry,
   output logic                     rsp_zero,
   output logic                     rsp_negative,
   output logic                     rsp_overflow,
   output logic                     rsp_parity,
   output logic                     rsp_err,
   output logic [WIDTH-1:0]         alu_in_A,
   output logic [WIDTH-1:0]         alu_in_B,
   output logic                     alu_c_in,
   output logic [3:0]               alu_op,
   input  logic [WIDTH-1:0]         alu_out,
   input  logic                     alu_c_out,
   input  logic                     alu_f_zero,
   input  logic                     alu_f_negative,
   input  logic                     alu_f_overflow
);

   localparam int FULL  = WORDS * WIDTH;
   localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

   localparam logic [3:0] OP_PASS    = 4'h0;
   localparam logic [3:0] OP_ADD     = 4'h1;
   localparam logic [3:0] OP_ADD_CIN = 4'h2;
   localparam logic [3:0] OP_SUB     = 4'h3;
   localparam logic [3:0] OP_SUB_CIN = 4'h4;
   localparam logic [3:0] OP_INC     = 4'h6;
   localparam logic [3:0] OP_AND     = 4'h8;
   localparam logic [3:0] OP_OR      = 4'h9;
   localparam logic [3:0] OP_XOR     = 4'hA;
   localparam logic [3:0] OP_NOT     = 4'hB;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;
   localparam logic [1:0] S_ERR  = 2'd3;

   function automatic logic is_supported(input logic [3:0] op);
      case (op)
         OP_PASS, OP_ADD, OP_ADD_CIN, OP_SUB, OP_SUB_CIN,
         OP_INC, OP_AND, OP_OR, OP_XOR, OP_NOT: is_supported = 1'b1;
         default:                               is_supported = 1'b0;
      endcase
   endfunction

   function automatic logic is_arith(input logic [3:0] op);
      case (op)
         OP_ADD, OP_ADD_CIN, OP_SUB, OP_SUB_CIN, OP_INC: is_arith = 1'b1;
         default:                                       is_arith = 1'b0;
      endcase
   endfunction

   logic [1:0]       state;
   logic [IDX_W-1:0] idx;
   logic [3:0]       op_q;
   logic [FULL-1:0]  a_q;
   logic [FULL-1:0]  b_q;
   logic [FULL-1:0]  res_q;
   logic             cin_q;
   logic             chain_c;
   logic             zero_acc;
   logic             carry_q;
   logic             neg_q;
   logic             ovf_q;
   logic             first_limb;
   logic             in_resp;

   assign first_limb = (idx == '0);
   assign in_resp    = (state == S_RESP);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         idx      <= '0;
         op_q     <= OP_PASS;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         cin_q    <= 1'b0;
         chain_c  <= 1'b0;
         zero_acc <= 1'b0;
         carry_q  <= 1'b0;
         neg_q    <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  op_q     <= cmd_op;
                  a_q      <= cmd_a;
                  b_q      <= cmd_b;
                  cin_q    <= cmd_cin;
                  idx      <= '0;
                  chain_c  <= 1'b0;
                  zero_acc <= 1'b1;
                  state    <= is_supported(cmd_op) ? S_RUN : S_ERR;
               end
            end
            S_RUN: begin
               res_q[idx*WIDTH +: WIDTH] <= alu_out;
               zero_acc <= zero_acc & alu_f_zero;
               chain_c  <= alu_c_out;
               if (idx == LAST_IDX) begin
                  // Carry and overflow are meaningless for bitwise ops, so mask them there.
                  carry_q <= is_arith(op_q) & alu_c_out;
                  neg_q   <= alu_f_negative;
                  ovf_q   <= is_arith(op_q) & alu_f_overflow;
                  idx     <= '0;
                  state   <= S_RESP;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            S_RESP, S_ERR: begin
               if (rsp_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      alu_op   = OP_PASS;
      alu_in_A = '0;
      alu_in_B = '0;
      alu_c_in = 1'b0;
      if (state == S_RUN) begin
         alu_in_A = a_q[idx*WIDTH +: WIDTH];
         alu_in_B = b_q[idx*WIDTH +: WIDTH];
         case (op_q)
            OP_ADD: begin
               alu_op   = first_limb ? OP_ADD : OP_ADD_CIN;
               alu_c_in = first_limb ? 1'b0 : chain_c;
            end
            OP_ADD_CIN: begin
               alu_op   = OP_ADD_CIN;
               alu_c_in = first_limb ? cin_q : chain_c;
            end
            OP_SUB: begin
               alu_op   = first_limb ? OP_SUB : OP_SUB_CIN;
               alu_c_in = first_limb ? 1'b0 : chain_c;
            end
            OP_SUB_CIN: begin
               alu_op   = OP_SUB_CIN;
               alu_c_in = first_limb ? cin_q : chain_c;
            end
            OP_INC: begin
               // Upper limbs only propagate the increment's carry.
               alu_op   = first_limb ? OP_INC : OP_ADD_CIN;
               alu_in_B = '0;
               alu_c_in = first_limb ? 1'b0 : chain_c;
            end
            default: alu_op = op_q;
         endcase
      end
   end

   assign cmd_ready    = (state == S_IDLE);
   assign rsp_valid    = (state == S_RESP) || (state == S_ERR);
   assign rsp_err      = (state == S_ERR);
   assign rsp_result   = in_resp ? res_q : '0;
   assign rsp_carry    = in_resp & carry_q;
   assign rsp_zero     = in_resp & zero_acc;
   assign rsp_negative = in_resp & neg_q;
   assign rsp_overflow = in_resp & ovf_q;

`ifdef ALU_WIDE_SEQ_PARITY_EN
   assign rsp_parity = in_resp & (^res_q);
`else
   assign rsp_parity = 1'b0;
`endif

endmodule

// File: tb/tb_alu_wide_sequencer.sv
// Directed-vector bench for alu_wide_sequencer (WIDTH=8, WORDS=4) with a behavioural 8-bit ALU attached.
module tb_alu_wide_sequencer;

   localparam int W = 8;
   localparam int N = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [3:0]    cmd_op;
   logic [31:0]   cmd_a;
   logic [31:0]   cmd_b;
   logic          cmd_cin;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [31:0]   rsp_result;
   logic          rsp_carry, rsp_zero, rsp_negative, rsp_overflow, rsp_parity, rsp_err;
   logic [W-1:0]  alu_in_A, alu_in_B, alu_out;
   logic          alu_c_in, alu_c_out, alu_f_zero, alu_f_negative, alu_f_overflow;
   logic [3:0]    alu_op;

   int vec_count  = 0;
   int miss_count = 0;

   always #5 clk = ~clk;

   alu_wide_sequencer #(.WIDTH(W), .WORDS(N)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_negative(rsp_negative),
      .rsp_overflow(rsp_overflow), .rsp_parity(rsp_parity), .rsp_err(rsp_err),
      .alu_in_A(alu_in_A), .alu_in_B(alu_in_B), .alu_c_in(alu_c_in), .alu_op(alu_op),
      .alu_out(alu_out), .alu_c_out(alu_c_out), .alu_f_zero(alu_f_zero),
      .alu_f_negative(alu_f_negative), .alu_f_overflow(alu_f_overflow)
   );

   // Behavioural ALU: subtraction is A + ~B + c_in, so c_out=1 means no borrow.
   logic [8:0] s;
   logic [7:0] bx;
   logic       arith;
   always_comb begin
      bx    = alu_in_B;
      arith = 1'b1;
      s     = '0;
      case (alu_op)
         4'h0: begin s = {1'b0, alu_in_A}; arith = 1'b0; end
         4'h1: s = {1'b0, alu_in_A} + {1'b0, bx};
         4'h2: s = {1'b0, alu_in_A} + {1'b0, bx} + 9'(alu_c_in);
         4'h3: begin bx = ~alu_in_B; s = {1'b0, alu_in_A} + {1'b0, bx} + 9'd1; end
         4'h4: begin bx = ~alu_in_B; s = {1'b0, alu_in_A} + {1'b0, bx} + 9'(alu_c_in); end
         4'h5: begin bx = 8'h00; s = {1'b0, ~alu_in_A} + 9'd1; end
         4'h6: begin bx = 8'h00; s = {1'b0, alu_in_A} + 9'd1; end
         4'h7: begin bx = 8'hFF; s = {1'b0, alu_in_A} + 9'h0FF; end
         4'h8: begin s = {1'b0, alu_in_A & alu_in_B}; arith = 1'b0; end
         4'h9: begin s = {1'b0, alu_in_A | alu_in_B}; arith = 1'b0; end
         4'hA: begin s = {1'b0, alu_in_A ^ alu_in_B}; arith = 1'b0; end
         4'hB: begin s = {1'b0, ~alu_in_A}; arith = 1'b0; end
         4'hC: begin s = {1'b0, alu_in_A[7], alu_in_A[7:1]}; arith = 1'b0; end
         4'hD: begin s = {2'b00, alu_in_A[7:1]}; arith = 1'b0; end
         4'hE: begin s = {alu_in_A, 1'b0}; arith = 1'b0; end
         default: begin s = {1'b0, alu_in_A[6:0], alu_in_A[7]}; arith = 1'b0; end
      endcase
   end
   assign alu_out        = s[7:0];
   assign alu_c_out      = s[8];
   assign alu_f_zero     = (s[7:0] == 8'h00);
   assign alu_f_negative = s[7];
   assign alu_f_overflow = arith && (alu_in_A[7] == bx[7]) && (s[7] != alu_in_A[7]);

   // Issues one command; edges = rising edges after the accepting edge until rsp_valid is seen (bounded).
   task automatic do_cmd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, output int edges);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_cin = cin;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      edges = 0;
      while (rsp_valid !== 1'b1 && edges < 20) begin
         @(posedge clk);
         #1;
         edges++;
      end
   endtask

   task automatic release_rsp();
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
   endtask

   // Runs one supported command and compares result, flags {carry,zero,neg,ovf,err} and latency.
   task automatic run_vec(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic cin,
                          input logic [31:0] exp_res, input logic [4:0] exp_flags);
      int edges;
      logic [4:0] flags;
      do_cmd(op, a, b, cin, edges);
      flags = {rsp_carry, rsp_zero, rsp_negative, rsp_overflow, rsp_err};
      vec_count++;
      if (edges !== N) begin
         miss_count++;
         $display("FAIL %s_latency got %0d edges want %0d", name, edges, N);
      end
      vec_count++;
      if (rsp_result !== exp_res) begin
         miss_count++;
         $display("FAIL %s_result got %h want %h", name, rsp_result, exp_res);
      end
      vec_count++;
      if (flags !== exp_flags) begin
         miss_count++;
         $display("FAIL %s_flags got %b want %b", name, flags, exp_flags);
      end
      release_rsp();
   endtask

   task automatic test_reset();
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = 4'h0; cmd_a = '0; cmd_b = '0; cmd_cin = 1'b0;
      rsp_ready = 1'b0;
      #1;
      vec_count++;
      if ({cmd_ready, rsp_valid, rsp_err, rsp_carry, rsp_zero, rsp_negative, rsp_overflow, rsp_parity} !== 8'b1000_0000
          || rsp_result !== 32'h0) begin
         miss_count++;
         $display("FAIL reset_rsp got ready=%b valid=%b result=%h want ready=1 valid=0 result=0",
                  cmd_ready, rsp_valid, rsp_result);
      end
      vec_count++;
      if ({alu_op, alu_in_A, alu_in_B, alu_c_in} !== 21'h0) begin
         miss_count++;
         $display("FAIL reset_alu got op=%h A=%h B=%h cin=%b want all 0", alu_op, alu_in_A, alu_in_B, alu_c_in);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_add();
      logic exp_par;
      run_vec("add_carry_mid",   4'h1, 32'h00FFFFFF, 32'h00000001, 1'b0, 32'h01000000, 5'b00000);
      run_vec("add_wrap",        4'h1, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 5'b11000);
      run_vec("add_ovf",         4'h1, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 5'b00110);
      run_vec("addc_cin",        4'h2, 32'h00000010, 32'h00000020, 1'b1, 32'h00000031, 5'b00000);
      run_vec("inc_mid",         4'h6, 32'h0000FFFF, 32'h12345678, 1'b0, 32'h00010000, 5'b00000);
      run_vec("inc_wrap",        4'h6, 32'hFFFFFFFF, 32'h00000000, 1'b0, 32'h00000000, 5'b11000);
      // Parity and idle ALU drive checked on one more response, before it is released.
      begin
         int edges;
         do_cmd(4'h1, 32'h00000003, 32'h00000004, 1'b0, edges);
`ifdef ALU_WIDE_SEQ_PARITY_EN
         exp_par = 1'b1;
`else
         exp_par = 1'b0;
`endif
         vec_count++;
         if (rsp_parity !== exp_par) begin
            miss_count++;
            $display("FAIL parity got %b want %b", rsp_parity, exp_par);
         end
         vec_count++;
         if ({alu_op, alu_in_A, alu_in_B, alu_c_in} !== 21'h0 || rsp_result !== 32'h7) begin
            miss_count++;
            $display("FAIL resp_alu_idle got op=%h A=%h result=%h want op=0 A=0 result=7", alu_op, alu_in_A, rsp_result);
         end
         release_rsp();
      end
   endtask

   task automatic test_sub();
      run_vec("sub_ovf",  4'h3, 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 5'b10010);
      run_vec("subc_5_3", 4'h4, 32'h00000005, 32'h00000003, 1'b0, 32'h00000001, 5'b10000);
   endtask

   task automatic test_logic();
      run_vec("pass", 4'h0, 32'h12345678, 32'hFFFFFFFF, 1'b1, 32'h12345678, 5'b00000);
      run_vec("and",  4'h8, 32'hFF00FF00, 32'h0F0F0F0F, 1'b0, 32'h0F000F00, 5'b00000);
      run_vec("or0",  4'h9, 32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 5'b01000);
      run_vec("not",  4'hB, 32'h0F0F0F0F, 32'h00000000, 1'b0, 32'hF0F0F0F0, 5'b00100);
   endtask

   task automatic test_err();
      int edges;
      do_cmd(4'hC, 32'h12345678, 32'h1, 1'b1, edges);
      // The error response is already visible in the first cycle after acceptance.
      vec_count++;
      if (edges !== 0) begin
         miss_count++;
         $display("FAIL err_latency got %0d edges want 0 (valid in first cycle)", edges);
      end
      vec_count++;
      if ({rsp_err, rsp_carry, rsp_zero, rsp_negative, rsp_overflow, rsp_parity} !== 6'b100000
          || rsp_result !== 32'h0) begin
         miss_count++;
         $display("FAIL err_rsp got err=%b result=%h want err=1 result=0 flags=0", rsp_err, rsp_result);
      end
      release_rsp();
      run_vec("after_err_add", 4'h1, 32'h00000100, 32'h000000FF, 1'b0, 32'h000001FF, 5'b00000);
   endtask

   task automatic test_hold();
      int edges;
      do_cmd(4'hA, 32'hA5A5A5A5, 32'hFFFFFFFF, 1'b0, edges);
      vec_count++;
      if (edges !== N || rsp_result !== 32'h5A5A5A5A || rsp_carry !== 1'b0) begin
         miss_count++;
         $display("FAIL xor got edges=%0d result=%h carry=%b want 4 5a5a5a5a 0", edges, rsp_result, rsp_carry);
      end
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 4'h1; cmd_a = 32'h1; cmd_b = 32'h1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         vec_count++;
         if ({rsp_valid, cmd_ready, rsp_err} !== 3'b100 || rsp_result !== 32'h5A5A5A5A) begin
            miss_count++;
            $display("FAIL hold_%0d got valid=%b ready=%b result=%h want 1 0 5a5a5a5a",
                     i, rsp_valid, cmd_ready, rsp_result);
         end
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      release_rsp();
      @(posedge clk);
      #1;
      vec_count++;
      if ({rsp_valid, cmd_ready} !== 2'b01) begin
         miss_count++;
         $display("FAIL hold_ignored got valid=%b ready=%b want 0 1", rsp_valid, cmd_ready);
      end
   endtask

   task automatic test_reset_in_run();
      int seen = 0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 4'h1; cmd_a = 32'h11223344; cmd_b = 32'h01010101; cmd_cin = 1'b0;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      vec_count++;
      if ({alu_op, alu_in_A, alu_in_B} !== {4'h2, 8'h22, 8'h01}) begin
         miss_count++;
         $display("FAIL run_limb2 got op=%h A=%h B=%h want 2 22 01", alu_op, alu_in_A, alu_in_B);
      end
      #2;
      rst = 1'b1;
      #1;
      vec_count++;
      if ({rsp_valid, cmd_ready, alu_op, alu_in_A, alu_in_B, alu_c_in} !== {2'b01, 21'h0} || rsp_result !== 32'h0) begin
         miss_count++;
         $display("FAIL rst_in_run got valid=%b ready=%b op=%h A=%h result=%h want 0 1 0 0 0",
                  rsp_valid, cmd_ready, alu_op, alu_in_A, rsp_result);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (8) begin
         @(posedge clk);
         #1;
         if (rsp_valid === 1'b1) seen++;
      end
      vec_count++;
      if (seen !== 0) begin
         miss_count++;
         $display("FAIL rst_no_rsp got %0d valid cycles want 0", seen);
      end
      run_vec("post_rst_add", 4'h1, 32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 5'b00000);
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_err();
      test_logic();
      test_hold();
      test_reset_in_run();
      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
      $finish;
   end

endmodule
